uart_hex_loader: RTL

Byte-stream consumer sitting directly downstream of the `uart` block's receive FIFO, with its ack path feeding the `uart` transmit FIFO. It pops ASCII characters, assembles hex digits MSB-first into `DATA_WIDTH`-bit words and writes each completed word to a memory port at an auto-incrementing address. Each word, error or end-of-load is acknowledged with one ASCII character back through the UART. It is used to load program or data memory over the serial link.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/hex_decode.sv | 22 ++
 rtl/uart_hex_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and ASCII constants for the serial hex loader.
package uart_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_PARSE,
        S_WRITE,
        S_ERR,
        S_ACK,
        S_DONE
    } state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_Q_LO  = 8'h71;
    localparam logic [7:0] ASCII_Q_UP  = 8'h51;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_BANG  = 8'h21;
    localparam logic [7:0] ASCII_K     = 8'h4B;

    // Word separators: allowed only between complete words.
    function automatic logic is_sep(input logic [7:0] c);
        return (c == ASCII_SPACE) || (c == ASCII_CR) || (c == ASCII_LF);
    endfunction

    // Load terminator, either case.
    function automatic logic is_term(input logic [7:0] c);
        return (c == ASCII_Q_LO) || (c == ASCII_Q_UP);
    endfunction

endpackage

// File: rtl/hex_decode.sv
// Combinational ASCII hex digit decoder (0-9, a-f, A-F).
module hex_decode (
    input  logic [7:0] ascii,
    output logic [3:0] nibble,
    output logic       is_hex
);

    // Letters map through their low nibble: 'A'/'a' = x1 -> 1 + 9 = 10.
    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            is_hex = 1'b1;
            nibble = ascii[3:0];
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                     (ascii >= 8'h61 && ascii <= 8'h66)) begin
            is_hex = 1'b1;
            nibble = ascii[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_hex_loader.sv
// Pops ASCII hex from the UART receive FIFO, assembles words MSB-first,
// writes them to memory at an auto-incrementing address and acknowledges
// each word / error / terminator with one character on the transmit FIFO.
module uart_hex_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_empty,
    input  logic [7:0]            r_data,
    output logic                  rd_uart,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [7:0]            w_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  done,
    output logic                  err
);
    import uart_pkg::*;

    localparam int DIGITS = DATA_WIDTH / 4;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    state_t                state_q, state_nxt;
    logic [7:0]            byte_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            ack_q, ack_nxt;
    logic                  ack_ld;
    logic                  term_q, term_set;
    logic                  err_q;
    logic                  shift_en;

    logic [3:0]            nibble;
    logic                  is_hex;

    hex_decode u_hex_decode (
        .ascii  (byte_q),
        .nibble (nibble),
        .is_hex (is_hex)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_nxt;
    end

    // Next-state decode and single-cycle strobes. Reset gates the pop so
    // every output reads 0 while reset is held.
    always_comb begin
        state_nxt = state_q;
        rd_uart   = 1'b0;
        mem_we    = 1'b0;
        wr_uart   = 1'b0;
        shift_en  = 1'b0;
        ack_ld    = 1'b0;
        ack_nxt   = ack_q;
        term_set  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!rx_empty && !reset) begin
                    rd_uart   = 1'b1;
                    state_nxt = S_PARSE;
                end
            end
            S_PARSE: begin
                if (is_hex) begin
                    shift_en  = 1'b1;
                    state_nxt = (cnt_q == LAST_DIGIT) ? S_WRITE : S_FETCH;
                end else if (is_sep(byte_q)) begin
                    state_nxt = (cnt_q == '0) ? S_FETCH : S_ERR;
                end else if (is_term(byte_q)) begin
                    if (cnt_q == '0) begin
                        ack_ld    = 1'b1;
                        ack_nxt   = ASCII_K;
                        term_set  = 1'b1;
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end else begin
                    state_nxt = S_ERR;
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                ack_ld    = 1'b1;
                ack_nxt   = ASCII_DOT;
                state_nxt = S_ACK;
            end
            S_ERR: begin
                ack_ld    = 1'b1;
                ack_nxt   = ASCII_BANG;
                state_nxt = S_ACK;
            end
            S_ACK: begin
                // Hold here under backpressure; nothing is popped meanwhile.
                if (!tx_full) begin
                    wr_uart   = 1'b1;
                    state_nxt = term_q ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Latch the popped byte for classification in the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        byte_q <= 8'h00;
        else if (rd_uart) byte_q <= r_data;
    end

    // Word assembly and digit count; an error discards the partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == S_ERR) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == S_WRITE) begin
            cnt_q  <= '0;
        end else if (shift_en) begin
            word_q <= {word_q[DATA_WIDTH-5:0], nibble};
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Write address advances after each write and wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    addr_q <= '0;
        else if (state_q == S_WRITE)  addr_q <= addr_q + 1'b1;
    end

    // Pending ack byte and terminate flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q  <= 8'h00;
            term_q <= 1'b0;
        end else begin
            if (ack_ld)   ack_q  <= ack_nxt;
            if (term_set) term_q <= 1'b1;
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  err_q <= 1'b0;
        else if (state_q == S_ERR)  err_q <= 1'b1;
    end

    assign w_data    = wr_uart ? ack_q : 8'h00;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule
